// File: rtl/rom_spi_pkg.sv
// Shared constants and FSM state for the ROM SPI write responder.
// SPI SRAM opcodes, frame sizes and the controller state type.
package rom_spi_pkg;

   localparam logic [7:0] SPI_CMD_WRITE       = 8'h02;
   localparam logic [7:0] SPI_CMD_WRMR        = 8'h01;
   localparam logic [7:0] SPI_MODE_SEQUENTIAL = 8'h40;

   localparam int WRITE_FRAME_BITS = 48;
   localparam int INIT_FRAME_BITS  = 16;
   localparam int BIT_CNT_W        = $clog2(WRITE_FRAME_BITS + 1);

   typedef enum logic [2:0] {
      INIT_GAP,
      INIT_SHIFT,
      INIT_END,
      IDLE,
      SHIFT,
      END
   } state_t;

endpackage

// File: rtl/rom_spi_write_responder_spi_shift_out.sv
// MSB-first SPI mode-0 serializer, two clk cycles per bit.
// Frame is left-aligned; only the top `bits` bits are sent.
module spi_shift_out
   import rom_spi_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load,
   input  logic [WRITE_FRAME_BITS-1:0] frame,
   input  logic [BIT_CNT_W-1:0]        bits,
   output logic                        sck,
   output logic                        mosi,
   output logic                        done
);

   logic [WRITE_FRAME_BITS-1:0] shreg;
   logic [BIT_CNT_W-1:0]        left;
   logic                        active;
   logic                        phase;

   // last cycle of the final bit's high phase
   assign done = active & phase & (left == BIT_CNT_W'(1));

   // phase 0: sck low, bit on mosi; phase 1: sck high
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg  <= '0;
         left   <= '0;
         active <= 1'b0;
         phase  <= 1'b0;
         sck    <= 1'b0;
         mosi   <= 1'b0;
      end else if (load) begin
         shreg  <= frame;
         left   <= bits;
         active <= 1'b1;
         phase  <= 1'b0;
         sck    <= 1'b0;
         mosi   <= frame[WRITE_FRAME_BITS-1];
      end else if (active) begin
         if (!phase) begin
            phase <= 1'b1;
            sck   <= 1'b1;
         end else if (done) begin
            active <= 1'b0;
            phase  <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b0;
         end else begin
            phase <= 1'b0;
            sck   <= 1'b0;
            shreg <= shreg << 1;
            mosi  <= shreg[WRITE_FRAME_BITS-2];
            left  <= left - BIT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rom_spi_write_responder.sv
// ROM write handshake to serial SPI SRAM bridge.
// Puts the SRAM in sequential mode, then one WRITE frame per request.
module rom_spi_write_responder
   import rom_spi_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16,
   parameter int CS_GAP        = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rom_request,
   input  logic [ADDRESS_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0]    rom_data,
   output logic                     rom_busy,
   output logic                     rom_initialized,
   output logic                     spi_cs_n,
   output logic                     spi_sck,
   output logic                     spi_mosi
);

   state_t                      state;
   logic [15:0]                 gap_cnt;
   logic                        gap_last;
   logic                        init_go;
   logic                        write_go;
   logic                        load;
   logic [WRITE_FRAME_BITS-1:0] frame;
   logic [BIT_CNT_W-1:0]        bits;
   logic [23:0]                 byte_addr;
   logic                        spi_done;

   assign gap_last  = (gap_cnt == 16'(CS_GAP - 1));
   assign byte_addr = 24'({rom_address, 1'b0});
   assign init_go   = (state == INIT_GAP) && gap_last;
   assign write_go  = (state == IDLE) && rom_request;

   // pick the frame loaded on the edge that drops chip select
   always_comb begin
      load  = 1'b0;
      frame = '0;
      bits  = '0;
      unique case (1'b1)
         init_go: begin
            load  = 1'b1;
            frame = {SPI_CMD_WRMR, SPI_MODE_SEQUENTIAL,
                     {(WRITE_FRAME_BITS - INIT_FRAME_BITS){1'b0}}};
            bits  = BIT_CNT_W'(INIT_FRAME_BITS);
         end
         write_go: begin
            load  = 1'b1;
            frame = {SPI_CMD_WRITE, byte_addr, rom_data};
            bits  = BIT_CNT_W'(WRITE_FRAME_BITS);
         end
         default: ;
      endcase
   end

   spi_shift_out u_shift (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .frame (frame),
      .bits  (bits),
      .sck   (spi_sck),
      .mosi  (spi_mosi),
      .done  (spi_done)
   );

   // init / write sequencing with registered handshake and chip select
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= INIT_GAP;
         gap_cnt         <= '0;
         rom_busy        <= 1'b0;
         rom_initialized <= 1'b0;
         spi_cs_n        <= 1'b1;
      end else begin
         unique case (state)
            INIT_GAP: begin
               if (gap_last) begin
                  gap_cnt  <= '0;
                  spi_cs_n <= 1'b0;
                  state    <= INIT_SHIFT;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            INIT_SHIFT: begin
               if (spi_done) begin
                  spi_cs_n <= 1'b1;
                  state    <= INIT_END;
               end
            end
            INIT_END: begin
               if (gap_last) begin
                  gap_cnt         <= '0;
                  rom_initialized <= 1'b1;
                  state           <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            IDLE: begin
               if (rom_request) begin
                  rom_busy <= 1'b1;
                  spi_cs_n <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (spi_done) begin
                  spi_cs_n <= 1'b1;
                  state    <= END;
               end
            end
            END: begin
               if (gap_last) begin
                  gap_cnt  <= '0;
                  rom_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            default: state <= INIT_GAP;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_spi_write_responder.sv
// Directed bench for the ROM SPI write responder.
// Frames are rebuilt from mosi sampled on sck rising edges.
module tb_rom_spi_write_responder;

   logic        clk;
   logic        reset;
   logic        rom_request;
   logic [15:0] rom_address;
   logic [15:0] rom_data;
   logic        rom_busy;
   logic        rom_initialized;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_mosi;

   int n_checks;
   int n_fail;

   int          cyc;
   logic [63:0] cap;
   int          rises;
   int          cs_low;
   int          first_cs;
   int          busy_cnt;
   int          first_busy;
   int          first_init;
   int          sck_bad;
   logic        prev_sck;

   rom_spi_write_responder dut (
      .clk             (clk),
      .reset           (reset),
      .rom_request     (rom_request),
      .rom_address     (rom_address),
      .rom_data        (rom_data),
      .rom_busy        (rom_busy),
      .rom_initialized (rom_initialized),
      .spi_cs_n        (spi_cs_n),
      .spi_sck         (spi_sck),
      .spi_mosi        (spi_mosi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      cyc        = 0;
      cap        = '0;
      rises      = 0;
      cs_low     = 0;
      first_cs   = -1;
      busy_cnt   = 0;
      first_busy = -1;
      first_init = -1;
      sck_bad    = 0;
      prev_sck   = 1'b0;
   endtask

   task automatic observe(input int n);
      for (int i = 0; i < n; i++) begin
         if (spi_sck && !prev_sck) begin
            cap   = {cap[62:0], spi_mosi};
            rises++;
         end
         if (spi_sck && spi_cs_n) sck_bad++;
         if (!spi_cs_n) begin
            if (first_cs < 0) first_cs = cyc;
            cs_low++;
         end
         if (rom_busy) begin
            if (first_busy < 0) first_busy = cyc;
            busy_cnt++;
         end
         if (rom_initialized && first_init < 0) first_init = cyc;
         prev_sck = spi_sck;
         cyc++;
         tick();
      end
   endtask

   task automatic write_frame(input logic [15:0] a,
                              input logic [15:0] d);
      rom_address = a;
      rom_data    = d;
      rom_request = 1'b1;
      clear_obs();
      observe(1);
      rom_request = 1'b0;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      rom_request = 1'b0;
      rom_address = '0;
      rom_data    = '0;
      clear_obs();
      repeat (3) tick();

      // reset state
      check("rst_busy", 64'(rom_busy), 64'd0);
      check("rst_init", 64'(rom_initialized), 64'd0);
      check("rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("rst_sck", 64'(spi_sck), 64'd0);
      check("rst_mosi", 64'(spi_mosi), 64'd0);

      // 1: init sequence, request low
      reset = 1'b0;
      clear_obs();
      observe(37);
      check("init_cycle", 64'(first_init), 64'd36);
      check("init_first_cs", 64'(first_cs), 64'd2);
      check("init_cs_low", 64'(cs_low), 64'd32);
      check("init_rises", 64'(rises), 64'd16);
      check("init_bits", {48'd0, cap[15:0]}, 64'h0140);
      check("init_busy", 64'(busy_cnt), 64'd0);
      check("init_sck_cs", 64'(sck_bad), 64'd0);
      check("init_cs_after", 64'(spi_cs_n), 64'd1);

      // 2: single write 0x0003 / 0xBEEF
      write_frame(16'h0003, 16'hBEEF);
      observe(120);
      check("w1_first_busy", 64'(first_busy), 64'd1);
      check("w1_busy_len", 64'(busy_cnt), 64'd98);
      check("w1_first_cs", 64'(first_cs), 64'd1);
      check("w1_cs_low", 64'(cs_low), 64'd96);
      check("w1_rises", 64'(rises), 64'd48);
      check("w1_frame", {16'd0, cap[47:0]}, 64'h02000006BEEF);
      check("w1_sck_cs", 64'(sck_bad), 64'd0);
      check("w1_init_held", 64'(rom_initialized), 64'd1);

      // 4: back-to-back, second request in the cycle busy falls
      write_frame(16'h0000, 16'h1234);
      observe(98);
      check("b2b_a_frame", {16'd0, cap[47:0]}, 64'h020000001234);
      check("b2b_a_busy", 64'(busy_cnt), 64'd98);
      check("b2b_gap_low", 64'(rom_busy), 64'd0);
      write_frame(16'h0001, 16'h5678);
      observe(110);
      check("b2b_b_first_busy", 64'(first_busy), 64'd1);
      check("b2b_b_frame", {16'd0, cap[47:0]}, 64'h020000025678);
      check("b2b_b_rises", 64'(rises), 64'd48);
      check("b2b_b_busy", 64'(busy_cnt), 64'd98);

      // 5: inputs change mid-frame
      write_frame(16'h0010, 16'hA5C3);
      observe(30);
      rom_address = 16'hFFFF;
      rom_data    = 16'hFFFF;
      observe(90);
      check("mid_frame", {16'd0, cap[47:0]}, 64'h02000020A5C3);
      check("mid_busy", 64'(busy_cnt), 64'd98);

      // 6: reset during bit 20 of a write
      write_frame(16'h0042, 16'h9999);
      observe(40);
      check("pre_rst_rises", 64'(rises), 64'd20);
      check("pre_rst_busy", 64'(rom_busy), 64'd1);
      check("pre_rst_cs_n", 64'(spi_cs_n), 64'd0);
      reset = 1'b1;
      tick();
      check("mid_rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("mid_rst_sck", 64'(spi_sck), 64'd0);
      check("mid_rst_busy", 64'(rom_busy), 64'd0);
      check("mid_rst_init", 64'(rom_initialized), 64'd0);
      check("mid_rst_mosi", 64'(spi_mosi), 64'd0);

      // 3: request held high through reset and init
      rom_address = 16'h0100;
      rom_data    = 16'h0F0F;
      rom_request = 1'b1;
      tick();
      reset = 1'b0;
      clear_obs();
      observe(37);
      check("hold_init_cycle", 64'(first_init), 64'd36);
      check("hold_init_busy", 64'(busy_cnt), 64'd0);
      check("hold_init_bits", {48'd0, cap[15:0]}, 64'h0140);
      check("hold_init_rises", 64'(rises), 64'd16);
      check("hold_init_cs", 64'(cs_low), 64'd32);
      clear_obs();
      observe(1);
      rom_request = 1'b0;
      observe(110);
      check("hold_first_busy", 64'(first_busy), 64'd0);
      check("hold_busy_len", 64'(busy_cnt), 64'd98);
      check("hold_frame", {16'd0, cap[47:0]}, 64'h020002000F0F);
      check("hold_sck_cs", 64'(sck_bad), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
